// File: rtl/axi_lite_gpu.sv
// ---------------------------------------------------------------------------
// axi_lite_gpu : AXI4-Lite register front-end driving pixel writes into a framebuffer BRAM.
// Optional fill engine enabled by defining GPU_FILL_EN.     Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_lite_gpu #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int FBUF_ADDR_WIDTH   = 19,
  parameter int FBUF_DATA_WIDTH   = 8,
  parameter int FB_PIXELS         = 307200
) (
  input  logic                         s_axi_ctrl_aclk,
  input  logic                         s_axi_ctrl_areset,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
  input  logic                         s_axi_ctrl_arvalid,
  output logic                         s_axi_ctrl_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
  output logic [1:0]                   s_axi_ctrl_rresp,
  output logic                         s_axi_ctrl_rvalid,
  input  logic                         s_axi_ctrl_rready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
  input  logic                         s_axi_ctrl_awvalid,
  output logic                         s_axi_ctrl_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
  input  logic                         s_axi_ctrl_wvalid,
  output logic                         s_axi_ctrl_wready,
  output logic [1:0]                   s_axi_ctrl_bresp,
  output logic                         s_axi_ctrl_bvalid,
  input  logic                         s_axi_ctrl_bready,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data
);

  localparam logic [1:0]  C_OKAY   = 2'b00;
  localparam logic [1:0]  C_SLVERR = 2'b10;
  localparam logic [31:0] C_FB_PIX = 32'(FB_PIXELS);

  logic                       arready_q, rvalid_q;
  logic [1:0]                 rsel_q;
  logic [AXI_DATA_WIDTH-1:0]  rdata_q;
  logic                       awready_q, wready_q, aw_have_q, w_have_q, bvalid_q;
  logic [1:0]                 wsel_q, bresp_q;
  logic [AXI_DATA_WIDTH-1:0]  wdata_q;
  logic                       fbuf_en_q;
  logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr_q;
  logic [FBUF_DATA_WIDTH-1:0] fbuf_data_q;

  logic                       busy, fill_strobe;
  logic [FBUF_ADDR_WIDTH-1:0] fill_addr;
  logic [FBUF_DATA_WIDTH-1:0] fill_color;

  logic                       exec_d, pix_ok_d;
  logic [FBUF_ADDR_WIDTH-1:0] pix_addr_d;
  logic [1:0]                 bresp_d;
  logic [AXI_DATA_WIDTH-1:0]  rdata_d;

  assign exec_d     = aw_have_q && w_have_q && !bvalid_q;
  assign pix_addr_d = wdata_q[8 +: FBUF_ADDR_WIDTH];
  assign pix_ok_d   = (32'(pix_addr_d) < C_FB_PIX) && !busy;
  assign rdata_d    = (rsel_q == 2'd2) ? {{(AXI_DATA_WIDTH-1){1'b0}}, busy}
                                       : {AXI_DATA_WIDTH{1'b1}};

  always_comb begin
    bresp_d = C_OKAY;
    case (wsel_q)
      2'd0:    bresp_d = pix_ok_d ? C_OKAY : C_SLVERR;
      2'd1:    bresp_d = busy ? C_SLVERR : C_OKAY;
      default: bresp_d = C_OKAY;
    endcase
  end

`ifdef GPU_FILL_EN
  localparam logic [FBUF_ADDR_WIDTH:0] C_FILL_END = FB_PIXELS[FBUF_ADDR_WIDTH:0];

  logic                       fill_busy_q;
  logic [FBUF_ADDR_WIDTH:0]   fill_cnt_q;
  logic [FBUF_DATA_WIDTH-1:0] fill_color_q;
  logic                       fill_start_d;

  assign fill_start_d = exec_d && (wsel_q == 2'd1) && !fill_busy_q;

  // The counter runs one past the last pixel so busy stays up through the final strobe.
  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      fill_busy_q  <= 1'b0;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
    end else if (fill_start_d) begin
      fill_busy_q  <= 1'b1;
      fill_cnt_q   <= '0;
      fill_color_q <= wdata_q[FBUF_DATA_WIDTH-1:0];
    end else if (fill_busy_q) begin
      if (fill_cnt_q == C_FILL_END) fill_busy_q <= 1'b0;
      else                          fill_cnt_q  <= fill_cnt_q + 1'b1;
    end
  end

  assign busy        = fill_busy_q;
  assign fill_strobe = fill_busy_q && (fill_cnt_q != C_FILL_END);
  assign fill_addr   = fill_cnt_q[FBUF_ADDR_WIDTH-1:0];
  assign fill_color  = fill_color_q;
`else
  assign busy        = 1'b0;
  assign fill_strobe = 1'b0;
  assign fill_addr   = '0;
  assign fill_color  = '0;
`endif

  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rsel_q      <= '0;
      rdata_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_have_q   <= 1'b0;
      w_have_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      wsel_q      <= '0;
      bresp_q     <= '0;
      wdata_q     <= '0;
      fbuf_en_q   <= 1'b0;
      fbuf_addr_q <= '0;
      fbuf_data_q <= '0;
    end else begin
      arready_q <= 1'b0;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (rvalid_q) begin
        if (s_axi_ctrl_rready) rvalid_q <= 1'b0;
      end else if (s_axi_ctrl_arvalid) begin
        arready_q <= 1'b1;
        rsel_q    <= s_axi_ctrl_araddr[3:2];
      end

      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      if (s_axi_ctrl_awvalid && !awready_q && !aw_have_q) begin
        awready_q <= 1'b1;
        aw_have_q <= 1'b1;
        wsel_q    <= s_axi_ctrl_awaddr[3:2];
      end
      if (s_axi_ctrl_wvalid && !wready_q && !w_have_q) begin
        wready_q <= 1'b1;
        w_have_q <= 1'b1;
        wdata_q  <= s_axi_ctrl_wdata;
      end

      if (exec_d) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (bvalid_q && s_axi_ctrl_bready) begin
        bvalid_q  <= 1'b0;
        aw_have_q <= 1'b0;
        w_have_q  <= 1'b0;
      end

      // Pixel writes are refused while busy, so they never collide with fill strobes.
      fbuf_en_q <= 1'b0;
      if (exec_d && (wsel_q == 2'd0) && pix_ok_d) begin
        fbuf_en_q   <= 1'b1;
        fbuf_addr_q <= pix_addr_d;
        fbuf_data_q <= wdata_q[FBUF_DATA_WIDTH-1:0];
      end else if (fill_strobe) begin
        fbuf_en_q   <= 1'b1;
        fbuf_addr_q <= fill_addr;
        fbuf_data_q <= fill_color;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:4], s_axi_ctrl_araddr[1:0],
                         s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:4], s_axi_ctrl_awaddr[1:0],
                         wdata_q[AXI_DATA_WIDTH-1:FBUF_ADDR_WIDTH+8]};

  assign s_axi_ctrl_arready = arready_q;
  assign s_axi_ctrl_rvalid  = rvalid_q;
  assign s_axi_ctrl_rdata   = rdata_q;
  assign s_axi_ctrl_rresp   = C_OKAY;
  assign s_axi_ctrl_awready = awready_q;
  assign s_axi_ctrl_wready  = wready_q;
  assign s_axi_ctrl_bvalid  = bvalid_q;
  assign s_axi_ctrl_bresp   = bresp_q;
  assign fbuf_en_wr         = fbuf_en_q;
  assign fbuf_wrea          = fbuf_en_q;
  assign fbuf_addr          = fbuf_addr_q;
  assign fbuf_data          = fbuf_data_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_gpu.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_gpu : self-checking bench for axi_lite_gpu (table vectors + fbuf scoreboard).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_lite_gpu;

`ifdef GPU_FILL_EN
  localparam int PIX = 512;
`else
  localparam int PIX = 307200;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  axi_lite_gpu #(.FB_PIXELS(PIX)) dut (
    .s_axi_ctrl_aclk(clk),       .s_axi_ctrl_areset(rst),
    .s_axi_ctrl_araddr(araddr),  .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready),
    .s_axi_ctrl_rdata(rdata),    .s_axi_ctrl_rresp(rresp),
    .s_axi_ctrl_rvalid(rvalid),  .s_axi_ctrl_rready(rready),
    .s_axi_ctrl_awaddr(awaddr),  .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready),
    .s_axi_ctrl_wdata(wdata),    .s_axi_ctrl_wvalid(wvalid),   .s_axi_ctrl_wready(wready),
    .s_axi_ctrl_bresp(bresp),    .s_axi_ctrl_bvalid(bvalid),   .s_axi_ctrl_bready(bready),
    .fbuf_en_wr(fbuf_en_wr),     .fbuf_wrea(fbuf_wrea),
    .fbuf_addr(fbuf_addr),       .fbuf_data(fbuf_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_arr = 0, n_awr = 0, n_wr = 0;
  logic [26:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          strobe;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Handshake pulse counters and framebuffer scoreboard.
  always @(negedge clk) begin : monitor
    logic [26:0] e;
    if (arready) n_arr++;
    if (awready) n_awr++;
    if (wready)  n_wr++;
    if (fbuf_en_wr || fbuf_wrea) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fbuf_unexpected: got addr=%h data=%h, required no strobe", fbuf_addr, fbuf_data);
      end else begin
        e = exp_q.pop_front();
        if ({fbuf_addr, fbuf_data} !== e || fbuf_en_wr !== 1'b1 || fbuf_wrea !== 1'b1) begin
          n_fail++;
          $display("FAIL fbuf_write: got en=%b we=%b addr=%h data=%h, required addr=%h data=%h",
                   fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data, e[26:8], e[7:0]);
        end
      end
    end
  end

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    int base;
    bit seen;
    base = n_arr;
    seen = 1'b0;
    araddr = a; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid) begin seen = 1'b1; break; end
    end
    check("rvalid_seen", 32'(seen), 32'd1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    check("rvalid_clear", 32'(rvalid), 32'd0);
    check("arready_pulses", n_arr - base, 32'd1);
  endtask

  // lead > 0: W leads AW by that many cycles; lead < 0: AW leads W.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int lead,
                           output logic [1:0] resp);
    int baw, bw;
    bit seen;
    baw = n_awr; bw = n_wr; seen = 1'b0;
    awaddr = a; wdata = d;
    if (lead > 0) begin
      wvalid = 1'b1; @(posedge clk); #1 wvalid = 1'b0;
      repeat (lead - 1) begin @(posedge clk); #1; end
      awvalid = 1'b1; @(posedge clk); #1 awvalid = 1'b0;
    end else if (lead < 0) begin
      awvalid = 1'b1; @(posedge clk); #1 awvalid = 1'b0;
      repeat (-lead - 1) begin @(posedge clk); #1; end
      wvalid = 1'b1; @(posedge clk); #1 wvalid = 1'b0;
    end else begin
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bvalid) begin seen = 1'b1; break; end
    end
    check("bvalid_seen", 32'(seen), 32'd1);
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check("bvalid_clear", 32'(bvalid), 32'd0);
    check("awready_pulses", n_awr - baw, 32'd1);
    check("wready_pulses", n_wr - bw, 32'd1);
  endtask

  task automatic add(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] r, input logic [31:0] rd, input bit s);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.resp = r; v.rdata = rd; v.strobe = s;
    vecs.push_back(v);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    logic [1:0]  r;
    logic [18:0] oob, last;
    rst = 1'b1;
    araddr = '0; awaddr = '0; wdata = '0;
    arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;

    repeat (10) begin
      @(negedge clk);
      check("reset_outputs", 32'({arready, awready, wready, rvalid, bvalid, fbuf_en_wr, fbuf_wrea}), 32'd0);
    end
    check("reset_rdata_resp", rdata | 32'({rresp, bresp}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    oob  = 19'(PIX);
    last = 19'(PIX - 1);
    add(1'b0, 32'h01, '0, 2'b00, 32'hFFFFFFFF, 1'b0);
    add(1'b0, 32'h04, '0, 2'b00, 32'hFFFFFFFF, 1'b0);
    add(1'b0, 32'h08, '0, 2'b00, 32'h00000000, 1'b0);
    add(1'b0, 32'h0C, '0, 2'b00, 32'hFFFFFFFF, 1'b0);
    add(1'b1, 32'h00, 32'h00F00FE3, 2'b00, '0, 1'b1);
    add(1'b1, 32'h00, {5'b0, oob, 8'h55}, 2'b10, '0, 1'b0);
    add(1'b1, 32'h00, {5'b0, last, 8'h7A}, 2'b00, '0, 1'b1);
    add(1'b1, 32'h00, 32'hF8000123, 2'b00, '0, 1'b1);
    add(1'b1, 32'h08, 32'h00000155, 2'b00, '0, 1'b0);
    add(1'b1, 32'h0C, 32'h00000255, 2'b00, '0, 1'b0);
    add(1'b1, 32'h10, 32'h00000A11, 2'b00, '0, 1'b1);
`ifndef GPU_FILL_EN
    add(1'b1, 32'h04, 32'h0000001C, 2'b00, '0, 1'b0);
    add(1'b0, 32'h08, '0, 2'b00, 32'h00000000, 1'b0);
`endif

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        if (vecs[i].strobe) exp_q.push_back({vecs[i].data[26:8], vecs[i].data[7:0]});
        axi_write(vecs[i].addr, vecs[i].data, 0, r);
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'd0);
      end
    end

    exp_q.push_back({19'h00123, 8'h45});
    axi_write(32'h0, 32'h00012345, 3, r);
    check("w_before_aw_bresp", 32'(r), 32'd0);
    exp_q.push_back({19'h0ABCD, 8'h66});
    axi_write(32'h0, 32'h00ABCD66, -2, r);
    check("aw_before_w_bresp", 32'(r), 32'd0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

`ifdef GPU_FILL_EN
    for (int i = 0; i < PIX; i++) exp_q.push_back({19'(i), 8'h1C});
    axi_write(32'h4, 32'h0000001C, 0, r);
    check("fill_bresp", 32'(r), 32'd0);
    axi_read(32'h8, d, r);
    check("status_busy", d, 32'd1);
    axi_write(32'h0, 32'h00000199, 0, r);
    check("pixel_during_fill_bresp", 32'(r), 32'd2);
    axi_write(32'h4, 32'h000000E0, 0, r);
    check("fill_during_fill_bresp", 32'(r), 32'd2);
    for (int i = 0; i < PIX + 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("fill_drained", exp_q.size(), 32'd0);
    axi_read(32'h8, d, r);
    check("status_idle", d, 32'd0);
    repeat (3) @(negedge clk);
    check("no_extra_strobes", exp_q.size(), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
